erm_biu: RTL

Parametrised bus interface unit for the next-generation ERM core. It decouples instruction fetch from execution through a prefetch queue of configurable depth and width. It arbitrates the single external memory/IO bus between data loads/stores and sequential instruction prefetch. It sits between the core's control unit and the external ADDR/DI/DO bus, replacing direct PC-driven addressing.

---
 rtl/erm_biu_if.sv | 24 ++
 rtl/erm_biu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/erm_biu_if.sv
// External memory/IO bus between the BIU (master) and the memory system (slave).
// Single outstanding transaction; request held until acknowledged, read data valid with ack.
interface erm_biu_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          ack;
  logic          we;
  logic          io;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, io, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, io, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/erm_biu.sv
// Bus interface unit: prefetch queue plus data/fetch arbitration on one external bus.
// Request issues one cycle after decision, held until ack; data beats fetch; prefetch stalls when queue is full.
module erm_biu #(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter int            QDEPTH   = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          init,
  erm_biu_if.master     mem,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  input  logic          if_ready,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_io,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done
);
  localparam int            PW    = $clog2(QDEPTH);
  localparam int            CW    = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state, state_nxt;
  logic          issue_fetch, issue_data, fetch_done, data_done;
  logic          push, pop;
  logic          mem_req, mem_we, mem_io;
  logic [AW-1:0] mem_addr, fetch_pc;
  logic [DW-1:0] mem_wdata;
  logic          discard;
  logic [DW-1:0] q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign mem.req   = mem_req;
  assign mem.we    = mem_we;
  assign mem.io    = mem_io;
  assign mem.addr  = mem_addr;
  assign mem.wdata = mem_wdata;

  assign if_valid = (count != '0);
  assign if_instr = q_mem[rd_ptr];

  always_comb begin
    state_nxt   = state;
    issue_fetch = 1'b0;
    issue_data  = 1'b0;
    fetch_done  = 1'b0;
    data_done   = 1'b0;
    case (state)
      IDLE: begin
        // d_done high means the core has not yet dropped the request just served
        if (d_req && !d_done) begin
          state_nxt  = DATA;
          issue_data = 1'b1;
        end else if ((count < QFULL) && !flush) begin
          state_nxt   = FETCH;
          issue_fetch = 1'b1;
        end
      end
      FETCH: begin
        if (mem.ack) begin
          state_nxt  = IDLE;
          fetch_done = 1'b1;
        end
      end
      DATA: begin
        if (mem.ack) begin
          state_nxt = IDLE;
          data_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push = fetch_done && !discard && !flush;
  assign pop  = if_valid && if_ready && !flush;

  always_ff @(posedge clk or negedge init) begin
    if (!init) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_io    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_rdata   <= '0;
      d_done    <= 1'b0;
      fetch_pc  <= RESET_PC;
      discard   <= 1'b0;
    end else begin
      mem_req <= (state_nxt != IDLE);
      d_done  <= data_done;
      if (issue_data) begin
        mem_we    <= d_we;
        mem_io    <= d_io;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (issue_fetch) begin
        mem_we   <= 1'b0;
        mem_io   <= 1'b0;
        mem_addr <= fetch_pc;
      end
      if (data_done && !mem_we) d_rdata <= mem.rdata;
      // A fetch still in flight at flush time completes on the bus but its data is stale
      if (flush) begin
        fetch_pc <= flush_pc;
        discard  <= (state == FETCH) && !mem.ack;
      end else if (fetch_done) begin
        discard <= 1'b0;
        if (!discard) fetch_pc <= fetch_pc + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= mem.rdata;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule
